hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 89 ++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: shadows EX/MEM/WB, detects load-use hazards and
// holds the front end while a multi-cycle multiply occupies EX.
module hazard_scoreboard #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        id_mul_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        mul_busy_o,
  output logic [15:0] stall_cnt_o
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } entry_t;

  localparam entry_t EmptyEntry = '0;

  entry_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [2:0]  mcnt_q, mcnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lu, issue, src_match;

  // x0 never carries a dependency, even from a load.
  assign src_match = (id_use_rs1_i && id_rs1_i == ex_q.rd) ||
                     (id_use_rs2_i && id_rs2_i == ex_q.rd);
  assign lu        = ex_q.v && ex_q.mr && (ex_q.rd != 5'd0) && src_match && id_valid_i;

  assign mul_busy_o  = (mcnt_q != 3'd0);
  assign stall_o     = mul_busy_o || (lu && !flush_i);
  assign bubble_o    = !mul_busy_o && (lu || flush_i || !id_valid_i);
  assign issue       = id_valid_i && !stall_o && !flush_i;
  assign stall_cnt_o = stall_cnt_q;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    ex_d        = EmptyEntry;
    mem_d       = ex_q;
    wb_d        = mem_q;
    mcnt_d      = 3'd0;
    stall_cnt_d = stall_cnt_q;
    if (mul_busy_o) begin
      // The multiply keeps EX; MEM receives a bubble each extra cycle.
      ex_d   = ex_q;
      mem_d  = EmptyEntry;
      mcnt_d = mcnt_q - 3'd1;
    end else if (issue) begin
      ex_d = '{v: 1'b1, rd: id_rd_i, rw: id_regwrite_i, mr: id_memread_i};
      if (id_mul_i) mcnt_d = 3'(MUL_LAT - 1);
    end
    if (stall_o && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= EmptyEntry;
      mem_q       <= EmptyEntry;
      wb_q        <= EmptyEntry;
      mcnt_q      <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      mcnt_q      <= mcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // WB mirrors the CPU pipeline but has no consumer inside this block.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule
